// File: rtl/srt4_div_ctrl.sv
// -----------------------------------------------------------------------------
// srt4_div_ctrl
// Sequencing controller for the radix-4 SRT divider core. It accepts RISC-V
// DIV/DIVU/REM/REMU requests, answers the architectural corner cases
// (divide-by-zero, signed overflow, zero dividend) without the core, and
// otherwise hands operand magnitudes to the core and applies the result signs
// on completion. One operation is in flight at a time.
//
// Optional feature: define SRT4_DIV_CTRL_RESULT_CACHE_EN to keep the operands
// and results of the last core-computed operation. A matching request
// (rs1, rs2, signedness) is then answered directly from the stored results.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 kill the in-flight operation, no response
//   req_valid_i/req_ready_o request handshake
//   req_op_i                00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_rs1_i/req_rs2_i     dividend / divisor
//   req_tag_i               destination tag, echoed on rsp_tag_o
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_data_o/rsp_tag_o    result and tag
//   busy_o                  controller not idle
//   core_start_o            one-cycle start pulse to the core
//   core_dividend_o/core_divisor_o   operand magnitudes to the core
//   core_quotient_i/core_remainder_i core results, valid with core_finish_i
//   core_finish_i/core_error_i       core done / core saw a zero divisor
// -----------------------------------------------------------------------------
module srt4_div_ctrl #(
  parameter int DW   = 32,
  parameter int TAGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [DW-1:0]   req_rs1_i,
  input  logic [DW-1:0]   req_rs2_i,
  input  logic [TAGW-1:0] req_tag_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_data_o,
  output logic [TAGW-1:0] rsp_tag_o,
  output logic            busy_o,
  output logic            core_start_o,
  output logic [DW-1:0]   core_dividend_o,
  output logic [DW-1:0]   core_divisor_o,
  input  logic [DW-1:0]   core_quotient_i,
  input  logic [DW-1:0]   core_remainder_i,
  input  logic            core_finish_i,
  input  logic            core_error_i
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_e;

  localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ONES    = '1;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic [DW-1:0]     dividend_q, dividend_d, divisor_q, divisor_d;
  logic [DW-1:0]     data_q, data_d;
  logic              start_q, start_d;

  // Request decode
  logic          accept, signed_req, neg1_req, neg2_req;
  logic          div0, ovf, zero_dividend;
  logic [DW-1:0] mag1, mag2, corner_data;

  assign req_ready_o   = (state_q == IDLE) && !flush_i;
  assign accept        = req_valid_i && req_ready_o;
  assign signed_req    = ~req_op_i[0];
  assign neg1_req      = signed_req & req_rs1_i[DW-1];
  assign neg2_req      = signed_req & req_rs2_i[DW-1];
  // Negating INT_MIN yields INT_MIN, which read unsigned is the right magnitude.
  assign mag1          = neg1_req ? -req_rs1_i : req_rs1_i;
  assign mag2          = neg2_req ? -req_rs2_i : req_rs2_i;
  assign div0          = (req_rs2_i == '0);
  assign ovf           = signed_req && (req_rs1_i == INT_MIN) && (req_rs2_i == ONES);
  assign zero_dividend = (req_rs1_i == '0);

  always_comb begin
    corner_data = '0;
    if (div0)     corner_data = req_op_i[1] ? req_rs1_i : ONES;
    else if (ovf) corner_data = req_op_i[1] ? '0 : req_rs1_i;
  end

  // Core completion: restore signs from the latched operand signs.
  logic [DW-1:0] q_fin, r_fin, rs1_orig;
  assign q_fin    = (neg1_q ^ neg2_q) ? -core_quotient_i : core_quotient_i;
  assign r_fin    = neg1_q ? -core_remainder_i : core_remainder_i;
  assign rs1_orig = neg1_q ? -dividend_q : dividend_q;

  logic          cache_hit;
  logic [DW-1:0] hit_data;

`ifdef SRT4_DIV_CTRL_RESULT_CACHE_EN
  logic          cache_valid_q;
  logic          cache_signed_q;
  logic [DW-1:0] cache_rs1_q, cache_rs2_q, cache_quo_q, cache_rem_q;
  logic          cache_fill;
  logic [DW-1:0] rs2_orig;

  assign rs2_orig   = neg2_q ? -divisor_q : divisor_q;
  assign cache_fill = (state_q == RUN) && core_finish_i && !core_error_i && !flush_i;
  assign cache_hit  = cache_valid_q && (cache_rs1_q == req_rs1_i) &&
                      (cache_rs2_q == req_rs2_i) && (cache_signed_q == signed_req);
  assign hit_data   = req_op_i[1] ? cache_rem_q : cache_quo_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)           cache_valid_q <= 1'b0;
    else if (cache_fill) cache_valid_q <= 1'b1;
  end

  // NOTE: the stored payload has no reset; it is never read while
  // cache_valid_q is low, so clearing it would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (cache_fill) begin
      cache_rs1_q    <= rs1_orig;
      cache_rs2_q    <= rs2_orig;
      cache_signed_q <= ~op_q[0];
      cache_quo_q    <= q_fin;
      cache_rem_q    <= r_fin;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tag_d      = tag_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    data_d     = data_q;
    start_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = req_op_i;
          tag_d  = req_tag_i;
          neg1_d = neg1_req;
          neg2_d = neg2_req;
          if (div0 || ovf || zero_dividend) begin
            state_d = RESP;
            data_d  = corner_data;
          end else if (cache_hit) begin
            state_d = RESP;
            data_d  = hit_data;
          end else begin
            state_d    = RUN;
            dividend_d = mag1;
            divisor_d  = mag2;
            start_d    = 1'b1;
          end
        end
      end
      RUN: begin
        if (flush_i) begin
          // A core that finishes in the flush cycle needs no draining.
          state_d = (core_finish_i || core_error_i) ? IDLE : DRAIN;
        end else if (core_error_i) begin
          state_d = RESP;
          data_d  = op_q[1] ? rs1_orig : ONES;
        end else if (core_finish_i) begin
          state_d = RESP;
          data_d  = op_q[1] ? r_fin : q_fin;
        end
      end
      DRAIN: begin
        if (core_finish_i || core_error_i) state_d = IDLE;
      end
      RESP: begin
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      tag_q      <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      data_q     <= data_d;
      start_q    <= start_d;
    end
  end

  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_data_o      = data_q;
  assign rsp_tag_o       = tag_q;
  assign busy_o          = (state_q != IDLE);
  assign core_start_o    = start_q;
  assign core_dividend_o = dividend_q;
  assign core_divisor_o  = divisor_q;

endmodule

// File: tb/tb_srt4_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_srt4_div_ctrl
// Directed bench for srt4_div_ctrl. A small behavioural divider core answers
// core_start after a fixed latency. Expected results are hand-computed
// constants. Build with SRT4_DIV_CTRL_RESULT_CACHE_EN to exercise the cache.
// -----------------------------------------------------------------------------
module tb_srt4_div_ctrl;

`ifdef SRT4_DIV_CTRL_RESULT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]  req_tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        busy, core_start;
  logic [31:0] core_dividend, core_divisor;
  logic [31:0] core_quotient = '0, core_remainder = '0;
  logic        core_finish = 1'b0;
  logic        core_error = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  srt4_div_ctrl #(.DW(32), .TAGW(5)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .req_rs1_i       (req_rs1),
    .req_rs2_i       (req_rs2),
    .req_tag_i       (req_tag),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_data_o      (rsp_data),
    .rsp_tag_o       (rsp_tag),
    .busy_o          (busy),
    .core_start_o    (core_start),
    .core_dividend_o (core_dividend),
    .core_divisor_o  (core_divisor),
    .core_quotient_i (core_quotient),
    .core_remainder_i(core_remainder),
    .core_finish_i   (core_finish),
    .core_error_i    (core_error)
  );

  always #5 clk = ~clk;

  // Behavioural core: finish is high in the fourth cycle after the start cycle.
  int          core_cnt = 0;
  logic [31:0] cap_a = '0, cap_b = 32'd1;
  always @(posedge clk) begin
    core_finish <= 1'b0;
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      cap_a     <= core_dividend;
      cap_b     <= core_divisor;
      core_cnt  <= 3;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_finish    <= 1'b1;
        core_quotient  <= cap_a / cap_b;
        core_remainder <= cap_a % cap_b;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request through to its handshake. use_core selects the core path
  // (start pulse, response later) versus the direct path (response at cycle 1).
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp,
                        input bit use_core, input logic [31:0] mag_a,
                        input logic [31:0] mag_b, input int hold);
    int s0;
    int waited;
    @(negedge clk);
    check({name, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    s0 = start_cnt;
    @(negedge clk);  // cycle 1
    req_valid = 1'b0;
    check({name, "_busy_c1"}, 32'(busy), 32'd1);
    check({name, "_ready_c1"}, 32'(req_ready), 32'd0);
    if (use_core) begin
      check({name, "_start_c1"}, 32'(core_start), 32'd1);
      check({name, "_valid_c1"}, 32'(rsp_valid), 32'd0);
      check({name, "_core_a"}, core_dividend, mag_a);
      check({name, "_core_b"}, core_divisor, mag_b);
    end else begin
      check({name, "_valid_c1"}, 32'(rsp_valid), 32'd1);
    end
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_data"}, rsp_data, exp);
    check({name, "_tag"}, 32'(rsp_tag), 32'(tag));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_hold_data"}, rsp_data, exp);
      check({name, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_post_ready"}, 32'(req_ready), 32'd1);
    check({name, "_starts"}, 32'(start_cnt - s0), use_core ? 32'd1 : 32'd0);
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_data", rsp_data, 32'd0);
    check("rst_tag", 32'(rsp_tag), 32'd0);
    check("rst_dividend", core_dividend, 32'd0);
    rst = 1'b0;

    // flush in IDLE blocks acceptance
    @(negedge clk);
    flush = 1'b1;
    #1 check("idle_flush_ready", 32'(req_ready), 32'd0);
    flush = 1'b0;

    // Signed core path with sign restoration
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'h0A, 32'hFFFF_FFFD, 1'b1, 32'd7, 32'd2, 0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'h0B, 32'hFFFF_FFFF, !CACHE, 32'd7, 32'd2, 0);

    // Divide by zero
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 5'h01, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'h02, 32'd5, 1'b0, 32'd0, 32'd0, 0);

    // Signed overflow
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'h03, 32'h8000_0000, 1'b0, 32'd0, 32'd0, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'h04, 32'd0, 1'b0, 32'd0, 32'd0, 0);

    // Zero dividend
    run_op("div_zero", 2'b00, 32'd0, 32'd3, 5'h05, 32'd0, 1'b0, 32'd0, 32'd0, 0);

    // INT_MIN magnitude through the core: -2^31 / 2 = -2^30
    run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 5'h06, 32'hC000_0000, 1'b1, 32'h8000_0000, 32'd2, 0);

    // Backpressure: response held for 5 cycles
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'h1F, 32'd14, 1'b1, 32'd100, 32'd7, 5);

    // Flush two cycles after core_start: DRAIN, no response
    begin
      int s0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd50; req_rs2 = 32'd5; req_tag = 5'h07;
      s0 = start_cnt;
      @(negedge clk);  // cycle 1
      req_valid = 1'b0;
      check("flush_start_c1", 32'(core_start), 32'd1);
      @(negedge clk);  // cycle 2
      @(negedge clk);  // cycle 3
      flush = 1'b1;
      @(negedge clk);  // cycle 4, DRAIN
      flush = 1'b0;
      check("flush_drain_busy", 32'(busy), 32'd1);
      check("flush_drain_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("flush_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check("flush_idle_busy", 32'(busy), 32'd0);
      check("flush_starts", 32'(start_cnt - s0), 32'd1);
    end
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 5'h08, 32'd3, 1'b1, 32'd9, 32'd3, 0);

    // Repeated operands: answered from the cache when it is built in
    run_op("divu_1000_33_a", 2'b01, 32'd1000, 32'd33, 5'h09, 32'd30, 1'b1, 32'd1000, 32'd33, 0);
    run_op("divu_1000_33_b", 2'b01, 32'd1000, 32'd33, 5'h0C, 32'd30, !CACHE, 32'd1000, 32'd33, 0);
    run_op("remu_1000_33", 2'b11, 32'd1000, 32'd33, 5'h0D, 32'd10, !CACHE, 32'd1000, 32'd33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
